// File: rtl/rare_node_activity_monitor.sv
// Multi-channel toggle monitor: counts node toggles over a programmed window, then
// streams one record per channel flagging low-activity (rare) nodes as trojan-trigger candidates.
module rare_node_activity_monitor #(
    parameter int NCH = 8,
    parameter int CW  = 16,
    parameter int WW  = 16,
    parameter int IW  = $clog2(NCH)
) (
    input  logic           CLK,
    input  logic           RSTB,
    input  logic           start,
    input  logic           abort,
    input  logic [WW-1:0]  win_len,
    input  logic [CW-1:0]  threshold,
    input  logic [NCH-1:0] node_in,
    output logic           busy,
    output logic           done,
    output logic           rpt_valid,
    input  logic           rpt_ready,
    output logic [IW-1:0]  rpt_idx,
    output logic [CW-1:0]  rpt_count,
    output logic           rpt_rare
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_REPORT} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt [NCH];
    logic [NCH-1:0] node_q;
    logic [WW-1:0]  win_cnt;
    logic [WW-1:0]  win_q;
    logic [CW-1:0]  threshold_q;
    logic [IW-1:0]  idx;
    logic           done_q;
    logic           hs;
    logic           last_hs;
    logic           win_last;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign hs       = (state == S_REPORT) && rpt_ready;
    assign last_hs  = hs && (idx == IW'(NCH - 1));
    // win_q is nonzero whenever COUNT is entered, so win_q-1 never underflows here
    assign win_last = (win_cnt == win_q - WW'(1));

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = (win_len != '0) ? S_COUNT : S_REPORT;
                S_COUNT:  if (win_last) state_nxt = S_REPORT;
                S_REPORT: if (last_hs) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            node_q      <= '0;
            win_cnt     <= '0;
            win_q       <= '0;
            threshold_q <= '0;
            idx         <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // counters are left intact; the next accepted start clears them
                idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            win_q       <= win_len;
                            threshold_q <= threshold;
                            node_q      <= node_in;
                            win_cnt     <= '0;
                            idx         <= '0;
                            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
                        end
                    end
                    S_COUNT: begin
                        for (int i = 0; i < NCH; i++) begin
                            if (node_in[i] != node_q[i]) cnt[i] <= sat_inc(cnt[i]);
                        end
                        node_q  <= node_in;
                        win_cnt <= win_cnt + WW'(1);
                    end
                    S_REPORT: begin
                        if (last_hs) begin
                            idx    <= '0;
                            done_q <= 1'b1;
                        end else if (hs) begin
                            idx <= idx + IW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign rpt_valid = (state == S_REPORT);
    assign rpt_idx   = idx;
    assign rpt_count = rpt_valid ? cnt[idx] : '0;
    assign rpt_rare  = rpt_valid && (cnt[idx] < threshold_q);

endmodule

// File: doc/rare_node_activity_monitor.md
Name: rare_node_activity_monitor

Overview:
- Parametrised, multi-channel successor to the single-node DFF sub-circuits in the Nt_Node trojan-detection set.
- Samples NCH internal netlist nodes over a programmable window and counts toggles per channel with saturating counters.
- After the window closes, streams one report record per channel over a valid/ready interface.
- Each record flags the channel as rare when its toggle count is below a programmable threshold, marking it as a trojan-trigger candidate.

Parameters:
- NCH, 8, number of monitored node channels (>=2)
- CW, 16, toggle-counter and threshold width
- WW, 16, window-length width
- IW, $clog2(NCH), channel index width (derived)

Ports:
- CLK  input  1  clock, all flops rising-edge
- RSTB  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begins a measurement (accepted only in IDLE)
- abort  input  1  synchronous abort, returns to IDLE from any state, no done pulse
- win_len  input  WW  window length in cycles, sampled on accepted start
- threshold  input  CW  rare threshold, sampled on accepted start
- node_in  input  NCH  monitored node values
- busy  output  1  high in COUNT and REPORT
- done  output  1  one-cycle pulse after the last record handshakes
- rpt_valid  output  1  report record valid
- rpt_ready  input  1  consumer ready
- rpt_idx  output  IW  channel index of current record
- rpt_count  output  CW  toggle count of channel rpt_idx
- rpt_rare  output  1  1 when rpt_count < threshold_q

Behaviour:
- Reset is asynchronous and active-low (RSTB=0). While RSTB=0, every flop clears:
  - state=IDLE
  - all outputs 0: busy, done, rpt_valid, rpt_idx, rpt_count, rpt_rare
  - all counters, node_q, win_cnt, win_q and threshold_q 0
- State IDLE:
  - On start=1 and abort=0: load win_q=win_len, threshold_q=threshold, node_q=node_in; clear all NCH counters and win_cnt.
  - Next state is COUNT if win_len!=0; otherwise REPORT with all counts 0.
- State COUNT:
  - Each cycle, for each channel i: if node_in[i]!=node_q[i], cnt[i] increments, saturating at 2^CW-1. Then node_q<=node_in.
  - win_cnt increments each cycle. The cycle with win_cnt==win_q-1 is the last counted cycle; the next state is REPORT.
  - Exactly win_q cycles are counted. The first compare is against the node value at the start cycle.
- State REPORT:
  - rpt_valid=1 starting the first cycle in REPORT. rpt_idx starts at 0.
  - rpt_count=cnt[rpt_idx]. rpt_rare=(cnt[rpt_idx]<threshold_q), unsigned compare. threshold_q=0 means rpt_rare is never set.
  - Handshake on rpt_valid & rpt_ready advances rpt_idx by 1.
  - Handshake at rpt_idx==NCH-1: next state IDLE, rpt_valid=0, done=1 for one cycle, busy=0.
  - rpt_valid, rpt_idx, rpt_count and rpt_rare hold stable while rpt_ready=0. rpt_valid never drops without a handshake, except on abort or reset.
  - Records can be accepted back-to-back, one per cycle.
- Common rules:
  - busy=1 exactly in COUNT and REPORT.
  - start is ignored when not in IDLE.
  - abort has priority over start and over handshake. abort in any state forces IDLE next cycle with rpt_valid=0 and no done; counters keep their values until the next accepted start.
  - node_in is the same clock domain; no synchronizer.
  - Arithmetic is unsigned. win_cnt is WW bits. A maximum window of 2^WW-1 cycles must not wrap before the compare terminates.
- Reset mid-operation: immediate asynchronous return to IDLE with all outputs 0; an in-flight record is discarded.

Test Plan:
1. Reset: RSTB=0 during COUNT with rpt_ready=1 -> busy, rpt_valid, done and rpt_idx are 0 asynchronously, before the next CLK edge.
2. NCH=8, win_len=10, threshold=3; node_in[0] toggles every cycle, node_in[1] toggles once, others constant.
   - Expected records: idx0 count=10 rare=0; idx1 count=1 rare=1; idx2..7 count=0 rare=1.
   - done pulses 1 cycle after idx7 handshake.
   - busy is high for 10 count cycles plus 8 report cycles.
3. Saturation, CW=4: win_len=40, channel 3 toggling -> rpt_count=15 for idx3, with no wrap to 8.
4. Backpressure: hold rpt_ready=0 for 5 cycles at idx2 -> rpt_valid=1 and idx/count/rare stable all 5 cycles; then rpt_ready=1 advances to idx3 next cycle.
5. win_len=0 with start -> REPORT on the next cycle, all 8 records count=0; start pulses issued during REPORT are ignored.
6. abort in COUNT cycle 4, and separately abort at idx5 with rpt_ready=1 -> IDLE next cycle, rpt_valid=0, done stays 0; a fresh start then reports counts from the new window only.
